// File: rtl/ps2_dev_io.sv
// PS/2 keyboard receiver with glitch-filtered clock, frame FSM, receive FIFO and a
// CPU-facing status/data word. Handshake: ps2_rd/ps2_we are single-cycle strobes.
module ps2_dev_io #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        ps2_rd,
  input  logic        ps2_we,
  input  logic [31:0] Peripheral_in,
  output logic [31:0] ps2_out,
  output logic        ps2_irq
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [4:0]    DEPTH_C  = 5'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // Synchronizers and clock filter
  logic       r_clk_s1, r_clk_s2;
  logic       r_dat_s1, r_dat_s2;
  logic       r_filt, r_filt_prev;
  logic [1:0] r_filt_cnt;
  logic       w_fall;
  logic       w_bit;

  // Frame FSM
  state_t          r_state;
  logic [7:0]      r_shift;
  logic [2:0]      r_bitcnt;
  logic            r_par;
  logic [TW-1:0]   r_tmo;
  logic            r_push;
  logic [7:0]      r_push_data;
  logic            r_ferr_set;
  logic            r_perr_set;

  // FIFO and sticky flags
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wptr, r_rptr;
  logic [4:0]      r_count;
  logic            r_ovf, r_perr, r_ferr;
  logic            w_empty, w_full, w_pop, w_push_ok, w_ovf_set, w_clr;
  logic [7:0]      w_head;
  logic            w_unused;

  assign w_unused = &{1'b0, Peripheral_in[31:1]};

  // The filter only flips after four consecutive samples disagreeing with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_s1    <= 1'b1;
      r_clk_s2    <= 1'b1;
      r_dat_s1    <= 1'b1;
      r_dat_s2    <= 1'b1;
      r_filt      <= 1'b1;
      r_filt_prev <= 1'b1;
      r_filt_cnt  <= 2'd0;
    end else begin
      r_clk_s1    <= ps2_clk;
      r_clk_s2    <= r_clk_s1;
      r_dat_s1    <= ps2_data;
      r_dat_s2    <= r_dat_s1;
      r_filt_prev <= r_filt;
      if (r_clk_s2 != r_filt) begin
        if (r_filt_cnt == 2'd3) begin
          r_filt     <= r_clk_s2;
          r_filt_cnt <= 2'd0;
        end else begin
          r_filt_cnt <= r_filt_cnt + 2'd1;
        end
      end else begin
        r_filt_cnt <= 2'd0;
      end
    end
  end

  assign w_fall = r_filt_prev & ~r_filt;
  assign w_bit  = r_dat_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_shift     <= 8'h00;
      r_bitcnt    <= 3'd0;
      r_par       <= 1'b0;
      r_tmo       <= '0;
      r_push      <= 1'b0;
      r_push_data <= 8'h00;
      r_ferr_set  <= 1'b0;
      r_perr_set  <= 1'b0;
    end else begin
      r_push     <= 1'b0;
      r_ferr_set <= 1'b0;
      r_perr_set <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_fall && !w_bit) begin
            r_state  <= S_DATA;
            r_bitcnt <= 3'd0;
          end
        end
        S_DATA: begin
          if (w_fall) begin
            r_shift  <= {w_bit, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) r_state <= S_PARITY;
          end
        end
        S_PARITY: begin
          if (w_fall) begin
            r_par   <= w_bit;
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_fall) begin
            r_state <= S_IDLE;
            if (!w_bit) begin
              r_ferr_set <= 1'b1;
            end else if (^{r_shift, r_par}) begin
              r_push      <= 1'b1;
              r_push_data <= r_shift;
            end else begin
              r_perr_set <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // Inter-edge watchdog; a stalled frame is abandoned as a framing error.
      if (r_state == S_IDLE) begin
        r_tmo <= '0;
      end else if (w_fall) begin
        r_tmo <= '0;
      end else if (r_tmo == TMO_LAST) begin
        r_tmo      <= '0;
        r_state    <= S_IDLE;
        r_shift    <= 8'h00;
        r_ferr_set <= 1'b1;
      end else begin
        r_tmo <= r_tmo + TW'(1);
      end
    end
  end

  assign w_empty   = (r_count == 5'd0);
  assign w_full    = (r_count == DEPTH_C);
  assign w_pop     = ps2_rd & ~w_empty;
  assign w_push_ok = r_push & (~w_full | w_pop);
  assign w_ovf_set = r_push & w_full & ~w_pop;
  assign w_clr     = ps2_we & Peripheral_in[0];

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= r_push_data;
  end

  // Set events take priority over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= 5'd0;
      r_ovf   <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + PW'(1);
      if (w_pop)     r_rptr <= r_rptr + PW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
      r_ovf  <= (r_ovf  & ~w_clr) | w_ovf_set;
      r_perr <= (r_perr & ~w_clr) | r_perr_set;
      r_ferr <= (r_ferr & ~w_clr) | r_ferr_set;
    end
  end

  assign w_head  = w_empty ? 8'h00 : r_mem[r_rptr];
  assign ps2_out = {~w_empty, r_ovf, r_perr, r_ferr, r_count[3:0], 16'h0000, w_head};
  assign ps2_irq = ~w_empty;

endmodule
